// File: rtl/soc_region_map_pkg.sv
// rtl/soc_region_map_pkg.sv - shared constants, default SoC map and register index helpers
package ariane_soc;

  localparam int unsigned SocRegions   = 12;
  localparam int unsigned SocAddrWidth = 64;
  localparam int unsigned MissCntWidth = 32;

  // Default region bases, listed from region 11 down to region 0 (DRAM first so it wins overlaps)
  localparam logic [SocRegions-1:0][SocAddrWidth-1:0] SocRstBase = {
    64'h0000_0000_5800_0000,  // 11 accelerator
    64'h0000_0000_5000_0000,  // 10 dma
    64'h0000_0000_4000_0000,  //  9 gpio
    64'h0000_0000_3000_0000,  //  8 ethernet
    64'h0000_0000_2000_0000,  //  7 spi
    64'h0000_0000_1800_0000,  //  6 timer
    64'h0000_0000_1000_0000,  //  5 uart
    64'h0000_0000_0c00_0000,  //  4 plic
    64'h0000_0000_0200_0000,  //  3 clint
    64'h0000_0000_0001_0000,  //  2 boot rom
    64'h0000_0000_0000_0000,  //  1 debug
    64'h0000_0000_8000_0000   //  0 dram
  };

  localparam logic [SocRegions-1:0][SocAddrWidth-1:0] SocRstLength = {
    64'h0000_0000_0000_1000,  // 11
    64'h0000_0000_0000_1000,  // 10
    64'h0000_0000_0000_1000,  //  9
    64'h0000_0000_0001_0000,  //  8
    64'h0000_0000_0080_0000,  //  7
    64'h0000_0000_0000_1000,  //  6
    64'h0000_0000_0000_1000,  //  5
    64'h0000_0000_0400_0000,  //  4
    64'h0000_0000_000c_0000,  //  3
    64'h0000_0000_0001_0000,  //  2
    64'h0000_0000_0000_1000,  //  1
    64'h0000_0000_4000_0000   //  0
  };

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned lock_idx(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned enable_idx(input int unsigned n);
    return 2 * n + 1;
  endfunction

  function automatic int unsigned miss_idx(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/soc_region_map_match.sv
// rtl/soc_region_map_match.sv - single-region address range comparator
module soc_region_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] base,
  input  logic [AddrWidth-1:0] length,
  input  logic                 enable,
  input  logic [AddrWidth-1:0] addr,
  output logic                 match
);

  // One extra bit so a region ending at the top of the address space never wraps to zero
  logic [AddrWidth:0] lo;
  logic [AddrWidth:0] hi;
  logic [AddrWidth:0] a;

  assign lo    = {1'b0, base};
  assign hi    = lo + {1'b0, length};
  assign a     = {1'b0, addr};
  assign match = enable && (length != '0) && (a >= lo) && (a < hi);

endmodule

// File: rtl/soc_region_map.sv
// rtl/soc_region_map.sv - programmable address region map with one-stage lookup pipeline
module soc_region_map
  import ariane_soc::*;
#(
  parameter int unsigned NumRegions = 12,
  parameter int unsigned AddrWidth  = 64,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RstBase   = SocRstBase,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] RstLength = SocRstLength,
  localparam int unsigned IdxWidth = idx_width(NumRegions)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [7:0]           cfg_addr_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic                 cfg_rvalid_o,
  output logic [AddrWidth-1:0] cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AddrWidth-1:0] in_addr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_hit_o,
  output logic [IdxWidth-1:0]  out_idx_o,
  output logic                 miss_irq_o
);

  localparam logic [7:0] LockIdx   = 8'(lock_idx(NumRegions));
  localparam logic [7:0] EnableIdx = 8'(enable_idx(NumRegions));
  localparam logic [7:0] MissIdx   = 8'(miss_idx(NumRegions));

  logic [AddrWidth-1:0]    base_q   [NumRegions];
  logic [AddrWidth-1:0]    length_q [NumRegions];
  logic [NumRegions-1:0]   lock_q;
  logic [NumRegions-1:0]   en_q;
  logic [MissCntWidth-1:0] miss_cnt_q;

  logic                 cfg_wr;
  logic [AddrWidth-1:0] rdata_d;
  logic                 err_d;
  logic                 rvalid_q;
  logic [AddrWidth-1:0] rdata_q;
  logic                 err_q;

  logic [NumRegions-1:0] match;
  logic                  hit_d;
  logic [IdxWidth-1:0]   idx_d;
  logic                  accept;
  logic                  out_valid_q;
  logic                  out_hit_q;
  logic [IdxWidth-1:0]   out_idx_q;
  logic                  miss_irq_q;

  assign cfg_gnt_o = cfg_req_i;
  assign cfg_wr    = cfg_req_i & cfg_we_i;

  for (genvar g = 0; g < NumRegions; g++) begin : gen_match
    soc_region_match #(
      .AddrWidth(AddrWidth)
    ) u_match (
      .base  (base_q[g]),
      .length(length_q[g]),
      .enable(en_q[g]),
      .addr  (in_addr_i),
      .match (match[g])
    );
  end

  // Priority encoder: scanning downward leaves the lowest matching index in place
  always_comb begin
    hit_d = 1'b0;
    idx_d = '0;
    for (int i = NumRegions - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_d = 1'b1;
        idx_d = IdxWidth'(i);
      end
    end
  end

  // Register read mux and access error decode; writes and errors return zero data
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    for (int i = 0; i < NumRegions; i++) begin
      if (cfg_addr_i == 8'(2 * i)) begin
        rdata_d = base_q[i];
        err_d   = cfg_we_i & lock_q[i];
      end
      if (cfg_addr_i == 8'(2 * i + 1)) begin
        rdata_d = length_q[i];
        err_d   = cfg_we_i & lock_q[i];
      end
    end
    if (cfg_addr_i == LockIdx)   rdata_d = AddrWidth'(lock_q);
    if (cfg_addr_i == EnableIdx) rdata_d = AddrWidth'(en_q);
    if (cfg_addr_i == MissIdx)   rdata_d = AddrWidth'(miss_cnt_q);
    if (cfg_addr_i > MissIdx)    err_d   = 1'b1;
    if (cfg_we_i || err_d)       rdata_d = '0;
  end

  // Config response: exactly one cycle after each granted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= cfg_req_i;
      rdata_q  <= cfg_req_i ? rdata_d : '0;
      err_q    <= cfg_req_i & err_d;
    end
  end

  // Region table, lock (set-only) and enable masks
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegions; i++) begin
        base_q[i]   <= RstBase[i];
        length_q[i] <= RstLength[i];
      end
      lock_q <= '0;
      en_q   <= '1;
    end else if (cfg_wr) begin
      for (int i = 0; i < NumRegions; i++) begin
        if (cfg_addr_i == 8'(2 * i) && !lock_q[i])     base_q[i]   <= cfg_wdata_i;
        if (cfg_addr_i == 8'(2 * i + 1) && !lock_q[i]) length_q[i] <= cfg_wdata_i;
      end
      if (cfg_addr_i == LockIdx)   lock_q <= lock_q | cfg_wdata_i[NumRegions-1:0];
      if (cfg_addr_i == EnableIdx) en_q   <= cfg_wdata_i[NumRegions-1:0];
    end
  end

  assign in_ready_o = !out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;

  // Saturating miss counter; a clear write wins over a same-cycle miss
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miss_cnt_q <= '0;
    end else if (cfg_wr && cfg_addr_i == MissIdx) begin
      miss_cnt_q <= '0;
    end else if (accept && !hit_d && miss_cnt_q != '1) begin
      miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // Lookup result stage; holds while the consumer stalls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      miss_irq_q  <= 1'b0;
    end else begin
      miss_irq_q <= accept & !hit_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_hit_q   <= hit_d;
        out_idx_q   <= idx_d;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_err_o    = err_q;
  assign out_valid_o  = out_valid_q;
  assign out_hit_o    = out_hit_q;
  assign out_idx_o    = out_idx_q;
  assign miss_irq_o   = miss_irq_q;

endmodule

// File: tb/tb_soc_region_map.sv
// tb/tb_soc_region_map.sv - scoreboard bench for soc_region_map
module tb_soc_region_map;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_req, cfg_we, cfg_gnt, cfg_rvalid, cfg_err;
  logic [7:0]  cfg_addr;
  logic [63:0] cfg_wdata, cfg_rdata;
  logic        in_valid, in_ready, out_valid, out_ready, out_hit, miss_irq;
  logic [63:0] in_addr;
  logic [3:0]  out_idx;

  int n_pass = 0;
  int n_total = 0;

  soc_region_map dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_gnt_o(cfg_gnt), .cfg_rvalid_o(cfg_rvalid), .cfg_rdata_o(cfg_rdata), .cfg_err_o(cfg_err),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_hit_o(out_hit), .out_idx_o(out_idx),
    .miss_irq_o(miss_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // reference model state
  logic [63:0] m_base [12];
  logic [63:0] m_len  [12];
  logic [11:0] m_en, m_lock;
  logic [31:0] m_miss;
  logic        m_ov, m_irq, m_rv;
  logic        exp_ready, exp_ov, exp_irq, exp_rv;
  logic        mon_on = 1'b0;
  logic [4:0]  q_look [$];
  logic [64:0] q_cfg  [$];
  logic [4:0]  lk_front;
  logic [64:0] cf_front;

  task automatic model_reset();
    m_base = '{64'h8000_0000, 64'h0, 64'h1_0000, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000,
               64'h1800_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h5000_0000, 64'h5800_0000};
    m_len  = '{64'h4000_0000, 64'h1000, 64'h1_0000, 64'hC_0000, 64'h0400_0000, 64'h1000,
               64'h1000, 64'h80_0000, 64'h1_0000, 64'h1000, 64'h1000, 64'h1000};
    m_en = 12'hFFF; m_lock = 12'h0; m_miss = 32'h0;
    m_ov = 1'b0; m_irq = 1'b0; m_rv = 1'b0;
    exp_ready = 1'b1; exp_ov = 1'b0; exp_irq = 1'b0; exp_rv = 1'b0;
    q_look.delete(); q_cfg.delete();
  endtask

  function automatic logic [4:0] model_look(input logic [63:0] a);
    for (int i = 0; i < 12; i++) begin
      if (m_en[i] && m_len[i] != 0 && {1'b0, a} >= {1'b0, m_base[i]} &&
          {1'b0, a} < ({1'b0, m_base[i]} + {1'b0, m_len[i]}))
        return {1'b1, 4'(i)};
    end
    return 5'b0;
  endfunction

  function automatic logic [64:0] model_read(input logic we, input logic [7:0] a);
    logic        err = 1'b0;
    logic [63:0] d = 64'h0;
    int          r = int'(a) / 2;
    if (a < 8'd24) begin
      d = a[0] ? m_len[r] : m_base[r];
      err = we & m_lock[r];
    end else if (a == 8'd24) d = {52'h0, m_lock};
    else if (a == 8'd25) d = {52'h0, m_en};
    else if (a == 8'd26) d = {32'h0, m_miss};
    else err = 1'b1;
    if (we || err) d = 64'h0;
    return {err, d};
  endfunction

  // one clock of stimulus; predicts what the DUT shows after the coming edge
  task automatic cyc(input logic req, input logic we, input logic [7:0] a, input logic [63:0] wd,
                     input logic iv, input logic [63:0] ia, input logic ordy);
    logic [4:0] lk;
    logic       acc;
    int         r;
    @(posedge clk); #1;
    cfg_req = req; cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    in_valid = iv; in_addr = ia; out_ready = ordy;
    exp_ready = !m_ov | ordy; exp_ov = m_ov; exp_irq = m_irq; exp_rv = m_rv;
    acc = iv & exp_ready;
    lk = model_look(ia);
    if (acc) q_look.push_back(lk);
    if (req) q_cfg.push_back(model_read(we, a));
    m_irq = acc & !lk[4];
    m_ov  = acc | (m_ov & !ordy);
    m_rv  = req;
    if (req && we && a == 8'd26) m_miss = 32'h0;
    else if (acc && !lk[4] && m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
    if (req && we) begin
      r = int'(a) / 2;
      if (a < 8'd24 && !m_lock[r]) begin
        if (a[0]) m_len[r] = wd; else m_base[r] = wd;
      end
      if (a == 8'd24) m_lock = m_lock | wd[11:0];
      if (a == 8'd25) m_en = wd[11:0];
    end
  endtask

  task automatic rd(input logic [7:0] a);            cyc(1, 0, a, 0, 0, 0, 1);  endtask
  task automatic wr(input logic [7:0] a, input logic [63:0] d); cyc(1, 1, a, d, 0, 0, 1); endtask
  task automatic look(input logic [63:0] ia);        cyc(0, 0, 0, 0, 1, ia, 1); endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  // scoreboard monitor, sampling mid-cycle
  always @(negedge clk) begin
    if (mon_on) begin
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("miss_irq", 64'(miss_irq), 64'(exp_irq));
      check("cfg_rvalid", 64'(cfg_rvalid), 64'(exp_rv));
      check("cfg_gnt", 64'(cfg_gnt), 64'(cfg_req));
      if (out_valid) begin
        if (q_look.size() == 0) check("look_underflow", 64'(q_look.size()), 64'd1);
        else begin
          lk_front = q_look[0];
          check("out_hit", 64'(out_hit), 64'(lk_front[4]));
          check("out_idx", 64'(out_idx), 64'(lk_front[3:0]));
          if (out_ready) void'(q_look.pop_front());
        end
      end
      if (cfg_rvalid) begin
        if (q_cfg.size() == 0) check("cfg_underflow", 64'(q_cfg.size()), 64'd1);
        else begin
          cf_front = q_cfg.pop_front();
          check("cfg_err", 64'(cfg_err), 64'(cf_front[64]));
          check("cfg_rdata", cfg_rdata, cf_front[63:0]);
        end
      end
    end
  end

  logic [63:0] pool [10];

  initial begin
    pool = '{64'h8000_0100, 64'h6000_0000, 64'h1000_0010, 64'h0201_2345, 64'h0,
             64'hFFFF_FFFF_FFFF_FFFF, 64'h1_FFFF, 64'h2_0000, 64'h7FFF_FFFF, 64'h2000_0040};
    rst = 1'b1; cfg_req = 0; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0;
    in_valid = 0; in_addr = 0; out_ready = 1;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rvalid", 64'(cfg_rvalid), 64'd0);
    check("rst_err", 64'(cfg_err), 64'd0);
    check("rst_irq", 64'(miss_irq), 64'd0);
    check("rst_hit", 64'(out_hit), 64'd0);
    check("rst_idx", 64'(out_idx), 64'd0);
    check("rst_rdata", cfg_rdata, 64'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    mon_on = 1'b1;

    rd(0); rd(1); rd(24); rd(25); rd(26); rd(27); rd(8'hFF);
    look(64'h8000_0100); look(64'h6000_0000); idle(1);
    rd(26); wr(26, 64'h1234); rd(26);
    wr(14, 64'h1000_0000); wr(24, 64'h80); wr(14, 64'h0); wr(15, 64'h0); rd(14);
    wr(24, 64'h0); rd(24); rd(15);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, pool[k], 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 1, pool[k + 2], 1);
    wr(25, 64'hFFD); wr(22, 64'hFFFF_FFFF_FFFF_F000); wr(23, 64'h2000);
    look(64'hFFFF_FFFF_FFFF_FFFF); look(64'h0); look(64'hFFFF_FFFF_FFFF_EFFF);
    cyc(1, 1, 0, 64'h9000_0000, 1, 64'h8000_0100, 1);
    look(64'h8000_0100); look(64'h9000_0000);
    cyc(1, 1, 26, 64'h0, 1, 64'h6000_0000, 1); rd(26);
    for (int k = 0; k < 300; k++)
      cyc($urandom_range(0, 2) == 0, 0, 8'($urandom_range(0, 27)), 0,
          $urandom_range(0, 3) != 0, pool[$urandom_range(0, 9)], $urandom_range(0, 3) != 0);
    idle(4);
    check("look_drained", 64'(q_look.size()), 64'd0);
    check("cfg_drained", 64'(q_cfg.size()), 64'd0);

    wr(26, 0);
    for (int k = 0; k < 5; k++) look(64'h6000_0000);
    rd(26);
    cyc(0, 0, 0, 0, 1, 64'h9000_0000, 0);
    cyc(1, 0, 26, 0, 0, 0, 0);
    #6;
    mon_on = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    cfg_req = 0; in_valid = 0; out_ready = 1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_hit", 64'(out_hit), 64'd0);
    check("async_rst_irq", 64'(miss_irq), 64'd0);
    @(posedge clk); #1;
    check("rst_drop_rvalid", 64'(cfg_rvalid), 64'd0);
    check("rst_drop_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    model_reset();
    mon_on = 1'b1;
    rd(26); rd(0); rd(24); rd(14);
    idle(3);
    check("final_look_drained", 64'(q_look.size()), 64'd0);
    check("final_cfg_drained", 64'(q_cfg.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
